uart_bus_responder: RTL and testbench

Memory-mapped UART peripheral on the CPU's 16-bit RAM bus: the responder end of the CPU's `RAMaddr`/`RAMin`/`RAMout`/`we`/`re`/`be` accesses, and the source of the CPU's `UART_intr` line. It decodes a 4-register window, serializes written bytes onto `txd` (8N1), deserializes `rxd` into a holding buffer, and raises a level interrupt while received data is pending.

---
 rtl/uart_bus_responder.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// uart_bus_responder: memory-mapped 8N1 UART on the CPU RAM bus.
// Register window BASE..BASE+7: DATA, STATUS, CTRL, DIV (word-aligned).
// Optional feature: define UART_RX_FIFO_EN for a 4-entry RX FIFO;
// otherwise a single holding register buffers received bytes.
module uart_bus_responder #(
   parameter logic [15:0] BASE      = 16'hFF00,
   parameter logic [15:0] DIV_RESET = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic        we,
   input  logic        re,
   input  logic        be,
   output logic        txd,
   input  logic        rxd,
   output logic        irq
);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // address decode
   logic       hit;
   logic [1:0] reg_idx;
   logic       data_wr, status_wr, ctrl_wr, div_wr, data_rd;
   logic       unused_bits;

   assign hit       = (addr[15:3] == BASE[15:3]);
   assign reg_idx   = addr[2:1];
   assign data_wr   = we & hit & (reg_idx == 2'd0);
   assign status_wr = we & hit & (reg_idx == 2'd1);
   assign ctrl_wr   = we & hit & (reg_idx == 2'd2);
   assign div_wr    = we & hit & (reg_idx == 2'd3);
   assign data_rd   = re & hit & (reg_idx == 2'd0);
   assign unused_bits = addr[0];

   // control/status registers
   logic [15:0] div_reg;
   logic        rx_ie_reg, rx_ovr_reg, frame_err_reg, tx_ovr_reg;
   logic        rx_ovr_set, frame_err_set, tx_ovr_set;
   logic [15:0] eff_div;

   // divisors below 2 would leave no room for the half-bit RX wait
   assign eff_div = (div_reg < 16'd2) ? 16'd2 : div_reg;

   // TX state
   tx_state_t   tx_state_reg, tx_state_next;
   logic [15:0] tx_cnt_reg, tx_cnt_next, tx_div_reg, tx_div_next;
   logic [2:0]  tx_bit_reg, tx_bit_next;
   logic [7:0]  tx_shift_reg, tx_shift_next;
   logic        txd_reg, txd_next;
   logic        tx_end, tx_accept, tx_busy;

   // RX state
   rx_state_t   rx_state_reg, rx_state_next;
   logic [15:0] rx_cnt_reg, rx_cnt_next, rx_div_reg, rx_div_next;
   logic [2:0]  rx_bit_reg, rx_bit_next;
   logic [7:0]  rx_shift_reg, rx_shift_next;
   logic        rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
   logic        rx_end, rx_fall, rx_store;

   // RX buffer view shared by both build variants
   logic        rx_valid, rx_pop, store_ok;
   logic [7:0]  rx_head;
   logic [2:0]  rx_count;

   assign tx_busy = (tx_state_reg != TX_IDLE);
   assign tx_end  = (tx_cnt_reg == 16'd0);
   // a write on the edge that ends STOP is accepted as the next frame
   assign tx_accept = data_wr & ((tx_state_reg == TX_IDLE) ||
                                 ((tx_state_reg == TX_STOP) && tx_end));
   assign rx_end  = (rx_cnt_reg == 16'd0);
   assign rx_fall = rxd_prev_reg & ~rxd_sync_reg;
   assign rx_pop  = data_rd & rx_valid;
   assign txd     = txd_reg;
   assign irq     = rx_ie_reg & rx_valid;

   // register writes; hardware set events win over write-1-to-clear
   always_ff @(posedge clk) begin
      if (reset) begin
         div_reg       <= DIV_RESET;
         rx_ie_reg     <= 1'b0;
         rx_ovr_reg    <= 1'b0;
         frame_err_reg <= 1'b0;
         tx_ovr_reg    <= 1'b0;
      end else begin
         if (div_wr) begin
            if (be) div_reg[7:0] <= wdata[7:0];
            else    div_reg      <= wdata;
         end
         if (ctrl_wr) rx_ie_reg <= wdata[0];
         if (status_wr) begin
            if (wdata[2]) rx_ovr_reg    <= 1'b0;
            if (wdata[3]) frame_err_reg <= 1'b0;
            if (wdata[4]) tx_ovr_reg    <= 1'b0;
         end
         if (rx_ovr_set)    rx_ovr_reg    <= 1'b1;
         if (frame_err_set) frame_err_reg <= 1'b1;
         if (tx_ovr_set)    tx_ovr_reg    <= 1'b1;
      end
   end

   // TX state register
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= 16'd0;
         tx_div_reg   <= 16'd2;
         tx_bit_reg   <= 3'd0;
         tx_shift_reg <= 8'd0;
         txd_reg      <= 1'b1;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_div_reg   <= tx_div_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         txd_reg      <= txd_next;
      end
   end

   // TX next state: each state lasts tx_div cycles, txd is registered
   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_cnt_reg;
      tx_div_next   = tx_div_reg;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      txd_next      = txd_reg;
      tx_ovr_set    = 1'b0;
      if (tx_state_reg != TX_IDLE) tx_cnt_next = tx_cnt_reg - 16'd1;
      case (tx_state_reg)
         TX_START: if (tx_end) begin
            tx_state_next = TX_DATA;
            tx_cnt_next   = tx_div_reg - 16'd1;
            tx_bit_next   = 3'd0;
            txd_next      = tx_shift_reg[0];
         end
         TX_DATA: if (tx_end) begin
            tx_cnt_next = tx_div_reg - 16'd1;
            if (tx_bit_reg == 3'd7) begin
               tx_state_next = TX_STOP;
               txd_next      = 1'b1;
            end else begin
               tx_bit_next   = tx_bit_reg + 3'd1;
               tx_shift_next = {1'b0, tx_shift_reg[7:1]};
               txd_next      = tx_shift_reg[1];
            end
         end
         TX_STOP: if (tx_end) begin
            tx_state_next = TX_IDLE;
            tx_cnt_next   = 16'd0;
         end
         default: ;
      endcase
      if (data_wr) begin
         if (tx_accept) begin
            tx_state_next = TX_START;
            tx_shift_next = wdata[7:0];
            tx_div_next   = eff_div;
            tx_cnt_next   = eff_div - 16'd1;
            txd_next      = 1'b0;
         end else begin
            tx_ovr_set = 1'b1;
         end
      end
   end

   // RX synchronizer, edge history and state register
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_reg <= 1'b1;
         rxd_sync_reg <= 1'b1;
         rxd_prev_reg <= 1'b1;
         rx_state_reg <= RX_IDLE;
         rx_cnt_reg   <= 16'd0;
         rx_div_reg   <= 16'd2;
         rx_bit_reg   <= 3'd0;
         rx_shift_reg <= 8'd0;
      end else begin
         rxd_meta_reg <= rxd;
         rxd_sync_reg <= rxd_meta_reg;
         rxd_prev_reg <= rxd_sync_reg;
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_div_reg   <= rx_div_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
      end
   end

   // RX next state: half-bit wait to centre on the start bit, then full bits
   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg;
      rx_div_next   = rx_div_reg;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_store      = 1'b0;
      frame_err_set = 1'b0;
      if (rx_state_reg != RX_IDLE) rx_cnt_next = rx_cnt_reg - 16'd1;
      case (rx_state_reg)
         RX_IDLE: if (rx_fall) begin
            rx_state_next = RX_START;
            rx_div_next   = eff_div;
            rx_cnt_next   = (eff_div >> 1) - 16'd1;
         end
         RX_START: if (rx_end) begin
            rx_state_next = rxd_sync_reg ? RX_IDLE : RX_DATA;
            rx_cnt_next   = rx_div_reg - 16'd1;
            rx_bit_next   = 3'd0;
         end
         RX_DATA: if (rx_end) begin
            rx_shift_next = {rxd_sync_reg, rx_shift_reg[7:1]};
            rx_cnt_next   = rx_div_reg - 16'd1;
            rx_bit_next   = rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
         end
         RX_STOP: if (rx_end) begin
            rx_state_next = RX_IDLE;
            rx_cnt_next   = 16'd0;
            rx_store      = rxd_sync_reg;
            frame_err_set = ~rxd_sync_reg;
         end
         default: ;
      endcase
   end

`ifdef UART_RX_FIFO_EN
   logic [7:0] fifo_mem [0:3];
   logic [1:0] wr_ptr_reg, rd_ptr_reg;
   logic [2:0] count_reg;

   assign rx_valid   = (count_reg != 3'd0);
   assign rx_head    = fifo_mem[rd_ptr_reg];
   assign rx_count   = count_reg;
   assign store_ok   = rx_store & ((count_reg != 3'd4) | rx_pop);
   assign rx_ovr_set = rx_store & ~store_ok;

   // FIFO storage, no reset needed on the data array
   always_ff @(posedge clk) begin
      if (store_ok) fifo_mem[wr_ptr_reg] <= rx_shift_reg;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 3'd0;
      end else begin
         if (store_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (rx_pop)   rd_ptr_reg <= rd_ptr_reg + 2'd1;
         count_reg <= count_reg + {2'd0, store_ok} - {2'd0, rx_pop};
      end
   end
`else
   logic       rx_valid_reg;
   logic [7:0] rx_data_reg;

   assign rx_valid   = rx_valid_reg;
   assign rx_head    = rx_data_reg;
   assign rx_count   = 3'd0;
   assign store_ok   = rx_store & (~rx_valid_reg | rx_pop);
   assign rx_ovr_set = rx_store & ~store_ok;

   // single holding register; a pop on the store edge frees the slot
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_valid_reg <= 1'b0;
         rx_data_reg  <= 8'd0;
      end else if (store_ok) begin
         rx_valid_reg <= 1'b1;
         rx_data_reg  <= rx_shift_reg;
      end else if (rx_pop) begin
         rx_valid_reg <= 1'b0;
      end
   end
`endif

   // combinational read mux, zero outside the window or when not reading
   always_comb begin
      logic [15:0] reg_val;
      reg_val = 16'd0;
      case (reg_idx)
         2'd0:    reg_val = {8'd0, rx_valid ? rx_head : 8'd0};
         2'd1:    reg_val = {8'd0, rx_count, tx_ovr_reg, frame_err_reg,
                             rx_ovr_reg, tx_busy, rx_valid};
         2'd2:    reg_val = {15'd0, rx_ie_reg};
         default: reg_val = div_reg;
      endcase
      rdata = 16'd0;
      if (re & hit) rdata = be ? {8'd0, reg_val[7:0]} : reg_val;
   end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed testbench for uart_bus_responder (DIV programmed to 4).
// Honours UART_RX_FIFO_EN for the expected STATUS/read-back values.
module tb_uart_bus_responder;

   logic        clk, reset;
   logic [15:0] addr, wdata, rdata;
   logic        we, re, be, txd, rxd, irq;
   int          errors = 0;
   int          checks = 0;
   logic [9:0]  frame;

`ifdef UART_RX_FIFO_EN
   localparam logic [15:0] ST_ONE = 16'h0021;
   localparam logic [15:0] ST_TWO = 16'h0041;
`else
   localparam logic [15:0] ST_ONE = 16'h0001;
   localparam logic [15:0] ST_TWO = 16'h0005;
`endif

   uart_bus_responder dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rdata(rdata),
      .we(we), .re(re), .be(be), .txd(txd), .rxd(rxd), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // all bus tasks start at a negedge and consume one rising edge
   task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic b);
      addr = a; wdata = d; be = b; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      $display("wr addr=%h data=%h be=%0d", a, d, b);
   endtask

   task automatic bus_read(input logic [15:0] a, input logic b, input string tag,
                           input logic [15:0] exp);
      addr = a; be = b; re = 1'b1;
      #1 check(tag, rdata, exp);
      $display("rd addr=%h be=%0d data=%h", a, b, rdata);
      @(negedge clk);
      re = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (4) @(negedge clk);
      end
      rxd = stop;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      $display("rx byte=%h stop=%0d", b, stop);
   endtask

   initial begin
      clk = 0; reset = 1; addr = 0; wdata = 0; we = 0; re = 0; be = 0; rxd = 1;
      repeat (3) @(negedge clk);
      check("reset_txd", {15'd0, txd}, 16'd1);
      check("reset_irq", {15'd0, irq}, 16'd0);
      check("reset_rdata", rdata, 16'd0);
      bus_read(16'hFF06, 1'b0, "reset_div", 16'd434);
      reset = 0;
      bus_write(16'hFF06, 16'h0004, 1'b0);
      bus_read(16'hFF02, 1'b0, "status_idle", 16'h0000);
      bus_read(16'hFF04, 1'b0, "ctrl_reset", 16'h0000);
      bus_read(16'hFF06, 1'b0, "div_word", 16'h0004);
      bus_read(16'hFF08, 1'b0, "miss_read", 16'h0000);

      // DIV byte write touches the low byte only
      bus_write(16'hFF06, 16'hAB12, 1'b1);
      bus_read(16'hFF06, 1'b0, "div_byte_wr", 16'h0012);
      bus_write(16'hFF06, 16'hAB00, 1'b0);
      bus_read(16'hFF07, 1'b1, "div_byte_rd", 16'h0000);
      bus_write(16'hFF06, 16'h0004, 1'b0);

      // frame 1: 0xA5, txd and TX_BUSY every cycle
      frame = {1'b1, 8'hA5, 1'b0};
      bus_write(16'hFF00, 16'h00A5, 1'b0);
      for (int i = 0; i < 40; i++) begin
         check($sformatf("tx1_bit%0d", i / 4), {15'd0, txd}, {15'd0, frame[i / 4]});
         bus_read(16'hFF02, 1'b0, "tx1_busy", 16'h0002);
      end
      check("tx1_idle_txd", {15'd0, txd}, 16'd1);
      bus_read(16'hFF02, 1'b0, "tx1_done", 16'h0000);

      // frame 2: 0x5A with a dropped write, TX_OVR clear, back-to-back next frame
      frame = {1'b1, 8'h5A, 1'b0};
      bus_write(16'hFF00, 16'h005A, 1'b0);
      check("tx2_bit0a", {15'd0, txd}, 16'd0);
      bus_write(16'hFF00, 16'h0033, 1'b0);
      check("tx2_bit0b", {15'd0, txd}, 16'd0);
      bus_read(16'hFF02, 1'b0, "tx_ovr_set", 16'h0012);
      bus_write(16'hFF02, 16'h0010, 1'b0);
      check("tx2_bit0c", {15'd0, txd}, 16'd0);
      bus_read(16'hFF02, 1'b0, "tx_ovr_clr", 16'h0002);
      for (int i = 4; i < 39; i++) begin
         check($sformatf("tx2_bit%0d", i / 4), {15'd0, txd}, {15'd0, frame[i / 4]});
         @(negedge clk);
      end
      check("tx2_stop_last", {15'd0, txd}, 16'd1);
      bus_write(16'hFF00, 16'h00FF, 1'b0);
      check("tx3_b2b_start", {15'd0, txd}, 16'd0);
      bus_read(16'hFF02, 1'b0, "tx3_b2b_busy", 16'h0002);
      repeat (39) @(negedge clk);
      check("tx3_idle_txd", {15'd0, txd}, 16'd1);
      bus_read(16'hFF02, 1'b0, "tx3_done", 16'h0000);

      // RX single byte with interrupt
      bus_write(16'hFF04, 16'h0001, 1'b0);
      check("irq_empty", {15'd0, irq}, 16'd0);
      rx_send(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      check("irq_rx", {15'd0, irq}, 16'd1);
      bus_read(16'hFF02, 1'b0, "rx_valid", ST_ONE);
      bus_read(16'hFF00, 1'b0, "rx_data", 16'h003C);
      check("irq_after_pop", {15'd0, irq}, 16'd0);
      bus_read(16'hFF00, 1'b0, "rx_empty_rd", 16'h0000);

      // two bytes without reading
      rx_send(8'h81, 1'b1);
      repeat (4) @(negedge clk);
      rx_send(8'h7E, 1'b1);
      repeat (4) @(negedge clk);
      check("irq_two", {15'd0, irq}, 16'd1);
      bus_read(16'hFF02, 1'b0, "rx_two_status", ST_TWO);
      bus_read(16'hFF00, 1'b1, "rx_first", 16'h0081);
`ifdef UART_RX_FIFO_EN
      bus_read(16'hFF02, 1'b0, "rx_after_first", 16'h0021);
      bus_read(16'hFF00, 1'b0, "rx_second", 16'h007E);
      bus_read(16'hFF02, 1'b0, "rx_drained", 16'h0000);
`else
      bus_read(16'hFF02, 1'b0, "rx_ovr_sticky", 16'h0004);
      bus_read(16'hFF00, 1'b0, "rx_dropped", 16'h0000);
      bus_write(16'hFF02, 16'h0004, 1'b0);
      bus_read(16'hFF02, 1'b0, "rx_ovr_clr", 16'h0000);
`endif

      // framing error
      rx_send(8'h55, 1'b0);
      repeat (4) @(negedge clk);
      check("irq_ferr", {15'd0, irq}, 16'd0);
      bus_read(16'hFF02, 1'b0, "frame_err", 16'h0008);
      bus_write(16'hFF02, 16'h0008, 1'b0);
      bus_read(16'hFF02, 1'b0, "frame_err_clr", 16'h0000);

      // one-cycle low glitch is a false start
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (60) @(negedge clk);
      bus_read(16'hFF02, 1'b0, "glitch", 16'h0000);

      // reset mid-frame with a byte pending
      rx_send(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      bus_write(16'hFF00, 16'h0000, 1'b0);
      repeat (5) @(negedge clk);
      check("pre_reset_txd", {15'd0, txd}, 16'd0);
      check("pre_reset_irq", {15'd0, irq}, 16'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_reset_txd", {15'd0, txd}, 16'd1);
      check("mid_reset_irq", {15'd0, irq}, 16'd0);
      bus_read(16'hFF02, 1'b0, "mid_reset_status", 16'h0000);
      bus_read(16'hFF04, 1'b0, "mid_reset_ctrl", 16'h0000);
      bus_read(16'hFF06, 1'b0, "mid_reset_div", 16'd434);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
